// File: rtl/stream_arbiter.sv
// Round-robin packet arbiter: merges INPUTS source streams onto one
// downstream stream, holding the grant for a whole packet.
module stream_arbiter #(
    parameter int T_DATA_WIDTH = 4,
    parameter int INPUTS = 3,
    localparam int ID_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [INPUTS-1:0],
    input  logic [INPUTS-1:0]       s_last_i,
    input  logic [INPUTS-1:0]       s_valid_i,
    output logic [INPUTS-1:0]       s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [ID_WIDTH-1:0]     m_id_o
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state, state_d;

    logic [ID_WIDTH-1:0] grant, grant_d;
    logic [ID_WIDTH-1:0] last_grant, last_grant_d;
    logic [ID_WIDTH-1:0] pick;
    logic                pick_vld;
    int                  idx;

    // Scan downward so the nearest index after last_grant wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = INPUTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % INPUTS;
            if (s_valid_i[idx]) begin
                pick     = ID_WIDTH'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(INPUTS - 1);
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        m_data_o     = '0;
        m_last_o     = 1'b0;
        m_valid_o    = 1'b0;
        m_id_o       = '0;
        s_ready_o    = '0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                m_data_o         = s_data_i[grant];
                m_last_o         = s_last_i[grant];
                m_valid_o        = s_valid_i[grant];
                m_id_o           = grant;
                s_ready_o[grant] = m_ready_i;
                if (m_valid_o && m_ready_i && m_last_o) begin
                    last_grant_d = grant;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: directed packet scenarios plus randomized
// traffic, checked against a packet-level round-robin model.
module tb_stream_arbiter;

    localparam int N = 3;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] s_data_i [N-1:0];
    logic [N-1:0] s_last_i;
    logic [N-1:0] s_valid_i;
    logic [N-1:0] s_ready_o;
    logic [W-1:0] m_data_o;
    logic         m_last_o;
    logic         m_valid_o;
    logic         m_ready_i;
    logic [1:0]   m_id_o;

    stream_arbiter #(.T_DATA_WIDTH(W), .INPUTS(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_data_i(s_data_i),
        .s_last_i(s_last_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o(m_data_o),
        .m_last_o(m_last_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_id_o(m_id_o)
    );

    always #5 clk = ~clk;

    logic [4:0] srcq [N][$];
    logic [6:0] log_q [$];
    int passed = 0;
    int total = 0;
    bit busy;
    int cur;
    int lastg;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (lastg + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        busy  = 1'b0;
        cur   = 0;
        lastg = N - 1;
    endtask

    task automatic add_pkt(input int s, input int len, input logic [W-1:0] d0);
        for (int b = 0; b < len; b++)
            srcq[s].push_back({b == len - 1, W'(d0 + W'(b))});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, m_valid_o, 0);
        chk({tag, "_last"}, m_last_o, 0);
        chk({tag, "_data"}, m_data_o, 0);
        chk({tag, "_id"}, m_id_o, 0);
        chk({tag, "_ready"}, s_ready_o, 0);
    endtask

    task automatic step(input logic [N-1:0] v, input logic r);
        logic [N-1:0] ev;
        int p;
        for (int i = 0; i < N; i++) begin
            if (v[i] && srcq[i].size() > 0) begin
                s_valid_i[i] = 1'b1;
                {s_last_i[i], s_data_i[i]} = srcq[i][0];
            end else begin
                s_valid_i[i] = 1'b0;
                s_last_i[i]  = 1'($urandom % 2);
                s_data_i[i]  = W'($urandom);
            end
        end
        m_ready_i = r;
        #4;
        if (busy) begin
            ev = '0;
            ev[cur] = r;
            chk("m_valid", m_valid_o, s_valid_i[cur]);
            chk("m_data", m_data_o, s_data_i[cur]);
            chk("m_last", m_last_o, s_last_i[cur]);
            chk("m_id", m_id_o, cur);
            chk("s_ready", s_ready_o, ev);
            if (s_valid_i[cur] && r) begin
                log_q.push_back({2'(cur), s_last_i[cur], s_data_i[cur]});
                void'(srcq[cur].pop_front());
                if (s_last_i[cur]) begin
                    lastg = cur;
                    busy  = 1'b0;
                end
            end
        end else begin
            chk_zero("idle");
            p = pick(s_valid_i);
            if (p >= 0) begin
                busy = 1'b1;
                cur  = p;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [6:0] exp_seq [6];
    logic [N-1:0] rv;
    int left;

    initial begin
        rst_n     = 1'b0;
        s_valid_i = '0;
        s_last_i  = '0;
        m_ready_i = 1'b1;
        for (int i = 0; i < N; i++) s_data_i[i] = '0;
        model_reset();
        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three 2-beat packets, served in order with idle gaps.
        add_pkt(0, 2, 4'h1);
        add_pkt(1, 2, 4'h5);
        add_pkt(2, 2, 4'h9);
        log_q.delete();
        repeat (10) step(3'b111, 1'b1);
        exp_seq = '{7'h01, 7'h12, 7'h25, 7'h36, 7'h49, 7'h5A};
        chk("seq_len", log_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("seq_beat", log_q[i], exp_seq[i]);

        // Wrap-around after source 2 was last served.
        add_pkt(2, 1, 4'h3);
        repeat (3) step(3'b100, 1'b1);
        add_pkt(0, 1, 4'h7);
        add_pkt(2, 1, 4'h8);
        step(3'b101, 1'b1);
        chk("wrap_id", m_id_o, 0);
        repeat (4) step(3'b101, 1'b1);

        // Granted source drops valid mid-packet.
        add_pkt(1, 3, 4'h4);
        add_pkt(0, 1, 4'hC);
        step(3'b010, 1'b1);
        step(3'b010, 1'b1);
        step(3'b001, 1'b1);
        step(3'b001, 1'b1);
        chk("gap_id", m_id_o, 1);
        repeat (6) step(3'b011, 1'b1);

        // Downstream stall on beat 0x5.
        add_pkt(1, 2, 4'h5);
        step(3'b010, 1'b1);
        repeat (3) step(3'b010, 1'b0);
        chk("stall_data", m_data_o, 5);
        repeat (3) step(3'b010, 1'b1);

        // Reset mid-packet from source 1.
        add_pkt(1, 3, 4'h1);
        step(3'b010, 1'b1);
        step(3'b010, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        srcq[1].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_pkt(0, 1, 4'h2);
        add_pkt(1, 1, 4'h3);
        step(3'b011, 1'b1);
        chk("favour0", m_id_o, 0);
        repeat (4) step(3'b011, 1'b1);

        // Randomized traffic.
        repeat (600) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 2)
                    add_pkt(i, $urandom_range(1, 4), W'($urandom));
                rv[i] = ($urandom % 4) != 0;
            end
            step(rv, ($urandom % 4) != 0);
        end

        // Drain: every queued beat must come out.
        repeat (80) step(3'b111, 1'b1);
        left = 0;
        for (int i = 0; i < N; i++) left += srcq[i].size();
        chk("drain", left, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 The block SHALL have parameter T_DATA_WIDTH, default 4, meaning bits per beat on every stream.
REQ-002 The block SHALL have parameter INPUTS, default 3, range 2..16, meaning the number of requesting source streams.
REQ-003 The block SHALL derive localparam ID_WIDTH = max(1, clog2(INPUTS)).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 s_data_i  input  [T_DATA_WIDTH-1:0] x [INPUTS-1:0] (unpacked)  per-source beat data.
REQ-007 s_last_i  input  [INPUTS-1:0]  per-source end-of-packet flag.
REQ-008 s_valid_i  input  [INPUTS-1:0]  per-source beat valid.
REQ-009 s_ready_o  output  [INPUTS-1:0]  per-source beat accept.
REQ-010 m_data_o  output  [T_DATA_WIDTH-1:0]  shared downstream data, feeds stream_upsize s_data_i.
REQ-011 m_last_o  output  1  downstream end-of-packet.
REQ-012 m_valid_o  output  1  downstream valid.
REQ-013 m_ready_i  input  1  downstream accept.
REQ-014 m_id_o  output  [ID_WIDTH-1:0]  index of source currently granted.

Function
REQ-015 The block SHALL implement FSM states IDLE and STREAM plus registers grant[ID_WIDTH] and last_grant[ID_WIDTH].
REQ-016 Handshake on any port SHALL occur on a rising edge where valid and ready are both 1; source beat i transfers iff s_valid_i[i] & s_ready_o[i].
REQ-017 In IDLE, if any s_valid_i bit is 1, the block SHALL pick the first valid index scanning (last_grant+1) mod INPUTS upward with wrap-around, load grant with it, and enter STREAM on the next edge.
REQ-018 In IDLE with no s_valid_i set, the block SHALL remain in IDLE with grant unchanged.
REQ-019 In IDLE, m_valid_o, m_last_o and all s_ready_o bits SHALL be 0, m_data_o SHALL be 0 and m_id_o SHALL be 0.
REQ-020 In STREAM, outputs SHALL be combinational pass-through: m_data_o = s_data_i[grant], m_last_o = s_last_i[grant], m_valid_o = s_valid_i[grant], m_id_o = grant.
REQ-021 In STREAM, s_ready_o[grant] SHALL equal m_ready_i and every other s_ready_o bit SHALL be 0.
REQ-022 Grant SHALL be held for the whole packet; the FSM SHALL leave STREAM only on a downstream handshake with m_last_o = 1, then load last_grant <= grant and return to IDLE.
REQ-023 Latency SHALL be one cycle from a valid request seen in IDLE to its first beat on m_*; one idle cycle SHALL separate consecutive packets.
REQ-024 A granted source deasserting s_valid mid-packet SHALL NOT lose its grant; m_valid_o follows it low and no other source is served.
REQ-025 m_ready_i = 0 in STREAM SHALL stall the granted source with no beat lost or duplicated.
REQ-026 Requests from non-granted sources SHALL be ignored until the FSM returns to IDLE; valid bits of waiting sources are never acknowledged early.
REQ-027 A single-beat packet (s_last_i = 1 on first beat) SHALL complete in one STREAM cycle when m_ready_i = 1.
REQ-028 Arbitration SHALL be starvation-free: any continuously requesting source is granted within INPUTS packets.

Reset
REQ-029 Asserting rst_n = 0 SHALL, asynchronously and at any state including mid-packet, force state IDLE, grant = 0, last_grant = INPUTS-1.
REQ-030 During and immediately after reset all outputs SHALL be 0; a packet cut by reset is abandoned and not resumed.
REQ-031 The first arbitration after reset SHALL favour source 0.

Verification (INPUTS=3, T_DATA_WIDTH=4, m_ready_i=1 unless stated)
REQ-032 Reset then sources 0,1,2 each hold a 2-beat packet (0x1,0x2 / 0x5,0x6 / 0x9,0xA) -> m_id_o sequence 0,0,1,1,2,2 with data 1,2,5,6,9,A, one idle cycle between packets, m_last_o on beats 2/4/6.
REQ-033 Source 2 only sends one packet, then sources 0 and 2 both request -> source 0 granted first (wrap-around from last_grant=2).
REQ-034 Source 1 mid-packet drops s_valid_i for 2 cycles while source 0 requests -> m_valid_o=0 for those 2 cycles, m_id_o stays 1, source 0 waits.
REQ-035 m_ready_i=0 for 3 cycles during beat 0x5 -> m_data_o holds 0x5, s_ready_o=000, beat delivered once after release.
REQ-036 rst_n pulsed low mid-packet from source 1 -> all outputs 0 immediately; after release, source 0 request granted first.
REQ-037 Arbiter connected to stream_upsize (T_DATA_RATIO=2) with 3-beat packets -> upsizer outputs 2 words per packet, second with m_keep_o=01 and m_last_o=1.
